// File: rtl/quarterwave_nco_pkg.sv
// Shared widths and quadrant encoding for the quarter-wave NCO.
// Optional cosine output is enabled by defining QUARTERWAVE_NCO_COSINE_EN.
package quarterwave_nco_pkg;
    localparam int PHASE_WIDTH   = 24;
    localparam int QLUT_WIDTH    = 8;
    localparam int DATA_WIDTH    = 7;
    localparam int QUADRANT_BITS = 2;
    localparam int ADDR_WIDTH    = QLUT_WIDTH - QUADRANT_BITS;

    typedef enum logic [QUADRANT_BITS-1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_t;
endpackage

// File: rtl/quarterwave_nco_if.sv
// NCO control, LUT and sample bus; master = controller/LUT side, slave = NCO.
// Cosine signals exist only when QUARTERWAVE_NCO_COSINE_EN is defined.
// Handshake: no ready; every cycle sine_valid is high, sine_out (and cosine_out) must be consumed.
interface quarterwave_nco_if;
    import quarterwave_nco_pkg::*;

    logic                         enable;
    logic                         sync_clear;
    logic [PHASE_WIDTH-1:0]       phase_inc;
    logic [ADDR_WIDTH-1:0]        lut_address;
    logic [DATA_WIDTH-1:0]        lut_value;
    logic signed [DATA_WIDTH:0]   sine_out;
    logic                         sine_valid;
`ifdef QUARTERWAVE_NCO_COSINE_EN
    logic [ADDR_WIDTH-1:0]        lut_address_q;
    logic [DATA_WIDTH-1:0]        lut_value_q;
    logic signed [DATA_WIDTH:0]   cosine_out;

    modport master (output enable, output sync_clear, output phase_inc, output lut_value,
                    output lut_value_q, input lut_address, input lut_address_q,
                    input sine_out, input sine_valid, input cosine_out);
    modport slave  (input enable, input sync_clear, input phase_inc, input lut_value,
                    input lut_value_q, output lut_address, output lut_address_q,
                    output sine_out, output sine_valid, output cosine_out);
`else
    modport master (output enable, output sync_clear, output phase_inc, output lut_value,
                    input lut_address, input sine_out, input sine_valid);
    modport slave  (input enable, input sync_clear, input phase_inc, input lut_value,
                    output lut_address, output sine_out, output sine_valid);
`endif
endinterface

// File: rtl/quarterwave_nco_quadrant_fold.sv
// Maps a full-wave index onto a quarter-wave table address plus a sign flag.
module quarterwave_nco_quadrant_fold
    import quarterwave_nco_pkg::*;
(
    input  logic [QLUT_WIDTH-1:0] index_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  neg_o
);
    quadrant_t             quad;
    logic [ADDR_WIDTH-1:0] offset;

    assign quad   = quadrant_t'(index_i[QLUT_WIDTH-1 -: QUADRANT_BITS]);
    assign offset = index_i[ADDR_WIDTH-1:0];

    // Odd quadrants run the table backwards; the second half-wave is negative.
    always_comb begin
        addr_o = offset;
        neg_o  = 1'b0;
        unique case (quad)
            Q0: begin addr_o = offset;  neg_o = 1'b0; end
            Q1: begin addr_o = ~offset; neg_o = 1'b0; end
            Q2: begin addr_o = offset;  neg_o = 1'b1; end
            Q3: begin addr_o = ~offset; neg_o = 1'b1; end
        endcase
    end
endmodule

// File: rtl/quarterwave_nco.sv
// Phase-accumulator NCO: accumulate, fold into a quarter-wave LUT, unfold sign.
// Define QUARTERWAVE_NCO_COSINE_EN for a second, quadrature-aligned cosine path.
module quarterwave_nco
    import quarterwave_nco_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    quarterwave_nco_if.slave nco
);
    logic [PHASE_WIDTH-1:0]     phase_acc_q, phase_acc_d;
    logic [QLUT_WIDTH-1:0]      index;
    logic [ADDR_WIDTH-1:0]      sin_addr, lut_address_q;
    logic                       sin_neg, neg_q;
    logic                       v_b_q, sine_valid_q;
    logic [DATA_WIDTH:0]        sin_mag, sine_d, sine_q;

    assign index = phase_acc_q[PHASE_WIDTH-1 -: QLUT_WIDTH];

    quarterwave_nco_quadrant_fold u_sin_fold (
        .index_i (index),
        .addr_o  (sin_addr),
        .neg_o   (sin_neg)
    );

    // Clear wins over increment; stage B still sees the pre-update phase.
    always_comb begin
        phase_acc_d = phase_acc_q;
        if (nco.sync_clear)
            phase_acc_d = '0;
        else if (nco.enable)
            phase_acc_d = phase_acc_q + nco.phase_inc;
    end

    assign sin_mag = {1'b0, nco.lut_value};
    assign sine_d  = neg_q ? -sin_mag : sin_mag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_acc_q   <= '0;
            lut_address_q <= '0;
            neg_q         <= 1'b0;
            v_b_q         <= 1'b0;
            sine_q        <= '0;
            sine_valid_q  <= 1'b0;
        end else begin
            phase_acc_q  <= phase_acc_d;
            v_b_q        <= nco.enable;
            sine_valid_q <= v_b_q;
            if (nco.enable) begin
                lut_address_q <= sin_addr;
                neg_q         <= sin_neg;
            end
            if (v_b_q)
                sine_q <= sine_d;
        end
    end

    assign nco.lut_address = lut_address_q;
    assign nco.sine_out    = sine_q;
    assign nco.sine_valid  = sine_valid_q;

`ifdef QUARTERWAVE_NCO_COSINE_EN
    logic [QLUT_WIDTH-1:0] cos_index;
    logic [ADDR_WIDTH-1:0] cos_addr, cos_address_q;
    logic                  cos_neg, cos_neg_q;
    logic [DATA_WIDTH:0]   cos_mag, cosine_d, cosine_q;

    // A quarter turn ahead of the sine index, wrapping naturally.
    assign cos_index = index + QLUT_WIDTH'(2 ** ADDR_WIDTH);

    quarterwave_nco_quadrant_fold u_cos_fold (
        .index_i (cos_index),
        .addr_o  (cos_addr),
        .neg_o   (cos_neg)
    );

    assign cos_mag  = {1'b0, nco.lut_value_q};
    assign cosine_d = cos_neg_q ? -cos_mag : cos_mag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cos_address_q <= '0;
            cos_neg_q     <= 1'b0;
            cosine_q      <= '0;
        end else begin
            if (nco.enable) begin
                cos_address_q <= cos_addr;
                cos_neg_q     <= cos_neg;
            end
            if (v_b_q)
                cosine_q <= cosine_d;
        end
    end

    assign nco.lut_address_q = cos_address_q;
    assign nco.cosine_out    = cosine_q;
`endif
endmodule

// File: tb/tb_quarterwave_nco.sv
// Directed bench for quarterwave_nco with a phase-level reference model and a
// continuously running compare process.
module tb_quarterwave_nco;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  quarterwave_nco_if nco ();

  quarterwave_nco dut (
    .clk (clk),
    .rst (rst),
    .nco (nco)
  );

  always #5 clk = ~clk;

  // Bench quarter-wave table: 0 at address 0, 62 at address 63.
  function automatic logic [6:0] lut_f(input logic [5:0] a);
    return 7'((int'(a) * 62) / 63);
  endfunction

  assign nco.lut_value = lut_f(nco.lut_address);

  // Reference: sample value from phase, by quadrant geometry.
  function automatic int model_wave(input logic [23:0] phase, input bit cosine);
    int idx, quad, pos, mag;
    idx  = (int'(phase >> 16) + (cosine ? 64 : 0)) % 256;
    quad = idx / 64;
    pos  = idx % 64;
    mag  = int'(lut_f(6'((quad % 2 == 1) ? (63 - pos) : pos)));
    return (quad >= 2) ? -mag : mag;
  endfunction

  int exp_q[$];
  int exp_cq[$];
  logic [23:0] model_phase = '0;
  int sam [0:511];
  int csam [0:511];
  int cont [0:511];
  int sam_cnt = 0;

`ifdef QUARTERWAVE_NCO_COSINE_EN
  assign nco.lut_value_q = lut_f(nco.lut_address_q);
`endif

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic step(input bit en, input bit clr, input logic [23:0] inc);
    @(negedge clk);
    nco.enable = en;
    nco.sync_clear = clr;
    nco.phase_inc = inc;
    if (en) begin
      exp_q.push_back(model_wave(model_phase, 1'b0));
      exp_cq.push_back(model_wave(model_phase, 1'b1));
    end
    if (clr) model_phase = '0;
    else if (en) model_phase = model_phase + inc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    nco.enable = 1'b0;
    nco.sync_clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    exp_cq.delete();
    model_phase = '0;
    sam_cnt = 0;
    rst = 1'b0;
  endtask

  // Compare process: valid timing, held output, and value against model.
  initial begin : compare
    bit prev_e = 1'b0;
    bit e;
    int last_out = 0;
    int exp_v;
    forever begin
      @(posedge clk);
      e = nco.enable && !rst;
      #1;
      exp_v = rst ? 0 : int'(prev_e);
      prev_e = e;
      check("sine_valid", int'(nco.sine_valid), exp_v);
      if (rst) begin
        last_out = 0;
        check("reset_sine_out", int'(nco.sine_out), 0);
      end else if (nco.sine_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sample", 1, 0);
        end else begin
          check("sine_out", int'(nco.sine_out), exp_q.pop_front());
`ifdef QUARTERWAVE_NCO_COSINE_EN
          check("cosine_out", int'(nco.cosine_out), exp_cq.pop_front());
          csam[sam_cnt] = int'(nco.cosine_out);
`else
          void'(exp_cq.pop_front());
`endif
        end
        sam[sam_cnt] = int'(nco.sine_out);
        if (sam_cnt < 511) sam_cnt++;
        last_out = int'(nco.sine_out);
      end else begin
        check("sine_out_hold", int'(nco.sine_out), last_out);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    nco.enable = 1'b0;
    nco.sync_clear = 1'b0;
    nco.phase_inc = '0;
    repeat (2) @(negedge clk);
    check("reset_lut_address", int'(nco.lut_address), 0);
    check("reset_sine_out_lit", int'(nco.sine_out), 0);
    rst = 1'b0;

    // Continuous run at one LUT step per sample.
    for (int i = 0; i < 257; i++) step(1'b1, 1'b0, 24'h010000);
    repeat (3) step(1'b0, 1'b0, 24'h010000);
    check("cont_s0", sam[0], 0);
    check("cont_s63", sam[63], 62);
    check("cont_s64", sam[64], 62);
    check("cont_s128", sam[128], 0);
    check("cont_s192", sam[192], -62);
    check("cont_s256", sam[256], 0);
`ifdef QUARTERWAVE_NCO_COSINE_EN
    check("cos_s0", csam[0], 62);
    check("cos_s64", csam[64], 0);
    check("cos_s128", csam[128], -62);
`endif
    for (int i = 0; i < 40; i++) cont[i] = sam[i];

    // Enable pulsed one cycle in three.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 24'h010000);
      step(1'b0, 1'b0, 24'h010000);
      step(1'b0, 1'b0, 24'h010000);
    end
    check("pulsed_count", sam_cnt, 40);
    for (int i = 0; i < 40; i += 8) check("pulsed_vs_cont", sam[i], cont[i]);

    // Maximum tuning word: wraps to all-ones phase.
    do_reset();
    step(1'b1, 1'b0, 24'hFFFFFF);
    step(1'b1, 1'b0, 24'hFFFFFF);
    @(posedge clk);
    #2;
    check("wrap_lut_address", int'(nco.lut_address), 0);
    repeat (3) step(1'b0, 1'b0, 24'hFFFFFF);
    check("wrap_s1", sam[1], 0);
    check("wrap_no_x", int'($isunknown(nco.sine_out)), 0);

    // sync_clear at index 32, then at phase 0x800000.
    do_reset();
    step(1'b1, 1'b0, 24'h200000);
    step(1'b1, 1'b1, 24'h200000);
    step(1'b1, 1'b0, 24'h800000);
    step(1'b1, 1'b1, 24'h800000);
    step(1'b1, 1'b0, 24'h010000);
    repeat (3) step(1'b0, 1'b0, 24'h010000);
    check("clr_s1", sam[1], 31);
    check("clr_s2", sam[2], 0);
    check("clr_s4", sam[4], 0);

    // Reset with samples in flight.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 24'h010000);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid", int'(nco.sine_valid), 0);
    check("async_rst_out", int'(nco.sine_out), 0);
    do_reset();
    step(1'b1, 1'b0, 24'h010000);
    step(1'b1, 1'b0, 24'h010000);
    repeat (3) step(1'b0, 1'b0, 24'h010000);
    check("post_rst_s0", sam[0], 0);
    check("post_rst_s1", sam[1], 0);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
